// File: rtl/loop_gate_delay_mc.sv
// Multi-channel gated delay stage: each channel is ANDed with tstate, delayed by a
// programmable number of cycles, then shaped as level / pulse / stretched pulse.
module loop_gate_delay_mc #(
  parameter int CH      = 4,
  parameter int MAX_DLY = 16,
  parameter int DLY_W   = 4,
  parameter int STR_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             CELSUB,
  input  logic [CH-1:0]    i0,
  input  logic             tstate,
  input  logic             cfg_we,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic [1:0]       cfg_mode,
  input  logic [STR_W-1:0] cfg_str,
  output logic [CH-1:0]    o,
  output logic             busy
);

  typedef enum logic [1:0] {
    MODE_LEVEL   = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_OFF     = 2'b11
  } mode_t;

  logic [DLY_W-1:0]           dly_reg;
  mode_t                      mode_reg;
  logic [STR_W-1:0]           str_reg;
  logic [CH-1:0][MAX_DLY-1:0] line_reg, line_next;
  logic [CH-1:0]              d_prev_reg;
  logic [CH-1:0][STR_W-1:0]   cnt_reg, cnt_next;
  logic [CH-1:0]              o_reg, o_next;
  logic                       busy_reg, busy_next;

  logic [CH-1:0]      g, d, rise, ch_busy;
  logic [MAX_DLY-1:0] tap_mask, act_mask;
  logic [DLY_W-1:0]   dly_clamped;
  logic               unused_supply;

  // Supply/ground/substrate pins exist only for netlist compatibility.
  assign unused_supply = ^{CELV, CELG, CELSUB};

  assign g           = i0 & {CH{tstate}};
  assign dly_clamped = (int'(cfg_dly) >= MAX_DLY) ? DLY_W'(MAX_DLY - 1) : cfg_dly;

  genvar gi;

  // tap_mask selects the output stage; act_mask covers the stages that are still
  // in flight towards the tap, so data already past the tap does not hold busy.
  for (gi = 0; gi < MAX_DLY; gi++) begin : g_stage
    assign tap_mask[gi] = (int'(dly_reg) == gi);
    assign act_mask[gi] = (int'(dly_reg) >= gi);
  end

  for (gi = 0; gi < CH; gi++) begin : g_ch
    assign d[gi]         = |(line_reg[gi] & tap_mask);
    assign rise[gi]      = d[gi] & ~d_prev_reg[gi];
    assign line_next[gi] = {line_reg[gi][MAX_DLY-2:0], g[gi]};

    assign cnt_next[gi] = (mode_reg != MODE_STRETCH)   ? '0 :
                          rise[gi]                     ? str_reg :
                          (cnt_reg[gi] != '0)          ? cnt_reg[gi] - STR_W'(1) : '0;

    assign o_next[gi] = ((mode_reg == MODE_LEVEL) && d[gi]) ||
                        ((mode_reg == MODE_PULSE) && rise[gi]) ||
                        ((mode_reg == MODE_STRETCH) && (rise[gi] || (cnt_reg[gi] != '0)));

    assign ch_busy[gi] = (|(line_next[gi] & act_mask)) | (|cnt_next[gi]);
  end

  assign busy_next = |ch_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_reg    <= '0;
      mode_reg   <= MODE_LEVEL;
      str_reg    <= '0;
      line_reg   <= '0;
      d_prev_reg <= '0;
      cnt_reg    <= '0;
      o_reg      <= '0;
      busy_reg   <= 1'b0;
    end else if (cfg_we) begin
      // A config write flushes everything in flight so no stale pulse can emerge.
      dly_reg    <= dly_clamped;
      mode_reg   <= mode_t'(cfg_mode);
      str_reg    <= cfg_str;
      line_reg   <= '0;
      d_prev_reg <= '0;
      cnt_reg    <= '0;
      o_reg      <= '0;
      busy_reg   <= 1'b0;
    end else begin
      line_reg   <= line_next;
      d_prev_reg <= d;
      cnt_reg    <= cnt_next;
      o_reg      <= o_next;
      busy_reg   <= busy_next;
    end
  end

  assign o    = o_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_loop_gate_delay_mc.sv
// Bench for loop_gate_delay_mc: hand-derived vector table run through a scoreboard,
// plus an asynchronous reset pulse in the middle of a stretched output.
module tb_loop_gate_delay_mc;
  localparam int CH      = 4;
  localparam int MAX_DLY = 8;
  localparam int DLY_W   = 4;
  localparam int STR_W   = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [DLY_W-1:0] cfg_dly  = '0;
  logic [1:0]       cfg_mode = '0;
  logic [STR_W-1:0] cfg_str  = '0;
  logic             tstate   = 1'b0;
  logic [CH-1:0]    i0       = '0;
  logic [CH-1:0]    o;
  logic             busy;

  always #5 clk = ~clk;

  loop_gate_delay_mc #(
    .CH(CH), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W), .STR_W(STR_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
    .i0(i0), .tstate(tstate),
    .cfg_we(cfg_we), .cfg_dly(cfg_dly), .cfg_mode(cfg_mode), .cfg_str(cfg_str),
    .o(o), .busy(busy)
  );

  typedef struct packed {
    logic       we;
    logic [3:0] dly;
    logic [1:0] mode;
    logic [3:0] str;
    logic       ts;
    logic [3:0] i0v;
    logic [3:0] eo;
    logic       eb;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_vec = 0;

  // Expected o/busy are those visible just after the edge that samples the vector.
  function automatic void add(int we, int dly, int mode, int str, int ts, int iv, int eo, int eb);
    vecs.push_back({1'(we), 4'(dly), 2'(mode), 4'(str), 1'(ts), 4'(iv), 4'(eo), 1'(eb)});
  endfunction

  function automatic void cfg(int dly, int mode, int str);
    add(1, dly, mode, str, 1, 0, 0, 0);
  endfunction

  function automatic void dat(int n, int ts, int iv, int eo, int eb);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, ts, iv, eo, eb);
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, expv);
    end
  endtask

  task automatic run_table();
    vec_t       v;
    logic [4:0] e;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      @(negedge clk);
      cfg_we   = v.we;
      cfg_dly  = v.dly;
      cfg_mode = v.mode;
      cfg_str  = v.str;
      tstate   = v.ts;
      i0       = v.i0v;
      exp_q.push_back({v.eo, v.eb});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("o", n_vec, o, e[4:1]);
      check("busy", n_vec, {3'b000, busy}, {3'b000, e[0]});
      $display("vec %0d we=%b ts=%b i0=%b -> o=%b busy=%b", n_vec, v.we, v.ts, v.i0v, o, busy);
      n_vec++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_o", -1, o, 4'b0000);
    check("reset_busy", -1, {3'b000, busy}, 4'b0000);
    rst_n = 1'b1;

    // LEVEL dly=3: one-cycle input appears 4 edges after it is sampled
    cfg(3, 0, 0);
    dat(1, 1, 4'h1, 4'h0, 1);
    dat(3, 1, 4'h0, 4'h0, 1);
    dat(1, 1, 4'h0, 4'h1, 0);
    dat(2, 1, 4'h0, 4'h0, 0);
    // gating: tstate low blocks all data; raise it, then drop it mid-stream
    dat(10, 0, 4'hF, 4'h0, 0);
    dat(4, 1, 4'hF, 4'h0, 1);
    dat(2, 1, 4'hF, 4'hF, 1);
    dat(3, 0, 4'hF, 4'hF, 1);
    dat(1, 0, 4'hF, 4'hF, 0);
    dat(1, 0, 4'hF, 4'h0, 0);
    // PULSE dly=0: held input gives one pulse, re-rise after a gap gives another
    cfg(0, 1, 0);
    dat(1, 1, 4'h4, 4'h0, 1);
    dat(1, 1, 4'h4, 4'h4, 1);
    dat(6, 1, 4'h4, 4'h0, 1);
    dat(1, 1, 4'h0, 4'h0, 0);
    dat(1, 1, 4'h4, 4'h0, 1);
    dat(1, 1, 4'h0, 4'h4, 0);
    dat(1, 1, 4'h0, 4'h0, 0);
    // STRETCH str=5: six cycles high
    cfg(0, 2, 5);
    dat(1, 1, 4'h1, 4'h0, 1);
    dat(5, 1, 4'h0, 4'h1, 1);
    dat(1, 1, 4'h0, 4'h1, 0);
    dat(1, 1, 4'h0, 4'h0, 0);
    // retrigger while the counter holds 2
    dat(1, 1, 4'h1, 4'h0, 1);
    dat(3, 1, 4'h0, 4'h1, 1);
    dat(1, 1, 4'h1, 4'h1, 1);
    dat(5, 1, 4'h0, 4'h1, 1);
    dat(1, 1, 4'h0, 4'h1, 0);
    dat(1, 1, 4'h0, 4'h0, 0);
    // STRETCH str=0 behaves as a single pulse
    cfg(0, 2, 0);
    dat(1, 1, 4'h1, 4'h0, 1);
    dat(1, 1, 4'h0, 4'h1, 0);
    dat(1, 1, 4'h0, 4'h0, 0);
    // clamp: dly=15 on an 8-deep line acts as dly=7
    cfg(15, 0, 0);
    dat(1, 1, 4'h8, 4'h0, 1);
    dat(7, 1, 4'h0, 4'h0, 1);
    dat(1, 1, 4'h0, 4'h8, 0);
    dat(1, 1, 4'h0, 4'h0, 0);
    // config write mid-stream (held two cycles) flushes data in flight
    cfg(3, 0, 0);
    dat(4, 1, 4'hF, 4'h0, 1);
    dat(1, 1, 4'hF, 4'hF, 1);
    add(1, 3, 0, 0, 1, 4'hF, 0, 0);
    add(1, 3, 0, 0, 1, 4'hF, 0, 0);
    dat(4, 1, 4'h0, 4'h0, 0);
    // STRETCH dly=1, into the middle of a stretched pulse
    cfg(1, 2, 5);
    dat(1, 1, 4'h1, 4'h0, 1);
    dat(1, 1, 4'h0, 4'h0, 1);
    dat(2, 1, 4'h0, 4'h1, 1);
    run_table();

    // asynchronous reset between edges while the output is stretched high
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_o", n_vec, o, 4'b0000);
    check("async_rst_busy", n_vec, {3'b000, busy}, 4'b0000);
    $display("async reset applied -> o=%b busy=%b", o, busy);
    @(negedge clk);
    rst_n = 1'b1;

    // config back to LEVEL dly=0: two-cycle input gives two-cycle output one edge later
    dat(2, 1, 4'h2, 4'h0, 1);
    vecs[1].eo = 4'h2;
    dat(1, 1, 4'h0, 4'h2, 0);
    dat(1, 1, 4'h0, 4'h0, 0);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
